// File: rtl/bus_xcvr_reg.sv
// Clocked bidirectional bus transceiver between a local bus (a) and a system bus (b),
// with registered direction control, enforced turnaround dead time and per-direction storage.
module bus_xcvr_reg #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  input  logic             dir,
  input  logic             g_n,
  input  logic             sab,
  input  logic             sba,
  input  logic             lat_ab,
  input  logic             lat_ba,
  output logic             a_oe,
  output logic             b_oe,
  output logic             turn
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE_AB = 2'd1,
    DRIVE_BA = 2'd2,
    TURN     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [3:0]       r_count;
  logic [3:0]       w_nextCount;
  logic [WIDTH-1:0] r_regAb;
  logic [WIDTH-1:0] r_regBa;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // TURN exits on the edge where the count has reached 1, so it lasts exactly TURN_CYCLES cycles
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    case (r_state)
      IDLE: begin
        if (!g_n) w_nextState = dir ? DRIVE_AB : DRIVE_BA;
      end
      DRIVE_AB: begin
        if (g_n) begin
          w_nextState = IDLE;
        end else if (!dir) begin
          w_nextState = TURN;
          w_nextCount = 4'(TURN_CYCLES);
        end
      end
      DRIVE_BA: begin
        if (g_n) begin
          w_nextState = IDLE;
        end else if (dir) begin
          w_nextState = TURN;
          w_nextCount = 4'(TURN_CYCLES);
        end
      end
      TURN: begin
        if (r_count > 4'd1) begin
          w_nextCount = r_count - 4'd1;
        end else if (g_n) begin
          w_nextState = IDLE;
        end else begin
          w_nextState = dir ? DRIVE_AB : DRIVE_BA;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regAb <= '0;
      r_regBa <= '0;
    end else begin
      if (lat_ab) r_regAb <= a;
      if (lat_ba) r_regBa <= b;
    end
  end

  always_comb begin
    b_oe = (r_state == DRIVE_AB);
    a_oe = (r_state == DRIVE_BA);
    turn = (r_state == TURN);
  end

  assign b = b_oe ? (sab ? r_regAb : a) : {WIDTH{1'bz}};
  assign a = a_oe ? (sba ? r_regBa : b) : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_xcvr_reg.sv
// Self-checking bench for bus_xcvr_reg: directed scenarios followed by random traffic,
// compared against a cycle-level behavioural model of the transceiver.
module tb_bus_xcvr_reg;

  localparam int WIDTH       = 16;
  localparam int TURN_CYCLES = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             dir, g_n, sab, sba, lat_ab, lat_ba;
  logic             a_oe, b_oe, turn;
  logic [WIDTH-1:0] tbA, tbB;
  wire  [WIDTH-1:0] a, b;

  int errors = 0;
  int checks = 0;

  // the bench only drives a side while the transceiver leaves it released
  assign a = a_oe ? {WIDTH{1'bz}} : tbA;
  assign b = b_oe ? {WIDTH{1'bz}} : tbB;

  bus_xcvr_reg #(.WIDTH(WIDTH), .TURN_CYCLES(TURN_CYCLES)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .dir(dir), .g_n(g_n),
    .sab(sab), .sba(sba), .lat_ab(lat_ab), .lat_ba(lat_ba),
    .a_oe(a_oe), .b_oe(b_oe), .turn(turn)
  );

  always #5 clk = ~clk;

  // model: which side is driven and how many dead cycles remain
  typedef enum {M_OFF, M_TO_B, M_TO_A, M_DEAD} mode_t;
  mode_t            mMode = M_OFF;
  int               mDeadLeft = 0;
  logic [WIDTH-1:0] mRegAb = '0;
  logic [WIDTH-1:0] mRegBa = '0;

  function automatic logic [WIDTH-1:0] expB();
    return sab ? mRegAb : tbA;
  endfunction

  function automatic logic [WIDTH-1:0] expA();
    return sba ? mRegBa : tbB;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".b_oe"}, 32'(b_oe), 32'(mMode == M_TO_B));
    chk({tag, ".a_oe"}, 32'(a_oe), 32'(mMode == M_TO_A));
    chk({tag, ".turn"}, 32'(turn), 32'(mMode == M_DEAD));
    if (mMode == M_TO_B) chk({tag, ".b"}, 32'(b), 32'(expB()));
    else                 chk({tag, ".bIn"}, 32'(b), 32'(tbB));
    if (mMode == M_TO_A) chk({tag, ".a"}, 32'(a), 32'(expA()));
    else                 chk({tag, ".aIn"}, 32'(a), 32'(tbA));
  endtask

  task automatic modelEdge();
    logic [WIDTH-1:0] aNow, bNow;
    aNow = (mMode == M_TO_A) ? expA() : tbA;
    bNow = (mMode == M_TO_B) ? expB() : tbB;
    if (reset) begin
      mMode  = M_OFF;
      mRegAb = '0;
      mRegBa = '0;
      return;
    end
    if (lat_ab) mRegAb = aNow;
    if (lat_ba) mRegBa = bNow;
    case (mMode)
      M_OFF:  if (!g_n) mMode = dir ? M_TO_B : M_TO_A;
      M_TO_B: if (g_n) mMode = M_OFF;
              else if (!dir) begin mMode = M_DEAD; mDeadLeft = TURN_CYCLES; end
      M_TO_A: if (g_n) mMode = M_OFF;
              else if (dir) begin mMode = M_DEAD; mDeadLeft = TURN_CYCLES; end
      M_DEAD: begin
        mDeadLeft--;
        if (mDeadLeft == 0) mMode = g_n ? M_OFF : (dir ? M_TO_B : M_TO_A);
      end
      default: mMode = M_OFF;
    endcase
  endtask

  task automatic applyStimulus(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic settle(input string tag);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset = 1'b1; dir = 1'b0; g_n = 1'b1; sab = 1'b0; sba = 1'b0;
    lat_ab = 1'b0; lat_ba = 1'b0; tbA = '0; tbB = '0;
    @(negedge clk);
    applyStimulus("reset");

    reset = 1'b0; g_n = 1'b0; dir = 1'b1; tbA = 16'h00A5;
    settle("preEnable");
    applyStimulus("enableAB");
    chk("passA5", 32'(b), 32'h00A5);

    dir = 1'b0; tbB = 16'h003C;
    applyStimulus("turn1");
    applyStimulus("turn2");
    applyStimulus("driveBA");
    chk("pass3C", 32'(a), 32'h003C);

    g_n = 1'b1;
    applyStimulus("idle1");
    tbA = 16'h005A; lat_ab = 1'b1;
    applyStimulus("latAb");
    lat_ab = 1'b0; tbA = 16'h00FF; sab = 1'b1; g_n = 1'b0; dir = 1'b1;
    applyStimulus("storedAB");
    chk("stored5A", 32'(b), 32'h005A);
    sab = 1'b0;
    settle("sabLive");
    chk("liveFF", 32'(b), 32'h00FF);

    dir = 1'b0;
    applyStimulus("turnAbort1");
    g_n = 1'b1; dir = 1'b1;
    applyStimulus("turnAbort2");
    dir = 1'b0;
    applyStimulus("turnAbortIdle");
    chk("abortIdleTurn", 32'(turn), 32'h0);

    tbB = 16'h0077; lat_ba = 1'b1; g_n = 1'b0; dir = 1'b0;
    applyStimulus("latBaEnable");
    lat_ba = 1'b0; sba = 1'b1;
    settle("stored77");
    chk("reg77", 32'(a), 32'h0077);
    reset = 1'b1;
    applyStimulus("midReset");
    reset = 1'b0;
    applyStimulus("reEnableBA");
    chk("clearedRegBa", 32'(a), 32'h0000);

    g_n = 1'b1; sba = 1'b0;
    applyStimulus("idle2");
    tbA = 16'hBEEF; sab = 1'b0; dir = 1'b1; g_n = 1'b0;
    applyStimulus("wideAB");
    chk("beef", 32'(b), 32'hBEEF);

    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 39) == 0);
      g_n    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) dir = ~dir;
      sab    = 1'($urandom);
      sba    = 1'($urandom);
      lat_ab = ($urandom_range(0, 3) == 0);
      lat_ba = ($urandom_range(0, 3) == 0);
      tbA    = 16'($urandom);
      tbB    = 16'($urandom);
      applyStimulus("random");
      if ($urandom_range(0, 4) == 0) begin
        sab = ~sab;
        sba = ~sba;
        settle("randomSel");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_xcvr_reg.md
Name: bus_xcvr_reg

Overview:
Parametrised, clocked bidirectional bus transceiver for PC-side bus buffering between a local bus (a) and a system bus (b). Extends the plain octal transceiver in four ways: configurable width, registered enable/direction control, an enforced dead-time turnaround on every direction reversal, and per-direction storage registers. Each direction can drive either real-time pass-through data or stored data.

Parameters:
WIDTH, 8, data width of each port (1..32)
TURN_CYCLES, 1, idle dead-time cycles inserted on a direction reversal (1..15)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
a  inout  WIDTH  side A bus
b  inout  WIDTH  side B bus
dir  input  1  1 = A to B (drive b), 0 = B to A (drive a)
g_n  input  1  active-low enable
sab  input  1  1 = b driven from reg_ab, 0 = b driven from a (real time)
sba  input  1  1 = a driven from reg_ba, 0 = a driven from b (real time)
lat_ab  input  1  capture a into reg_ab at clk edge
lat_ba  input  1  capture b into reg_ba at clk edge
a_oe  output  1  high while block drives a
b_oe  output  1  high while block drives b
turn  output  1  high during turnaround dead time

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset overrides all other inputs at the edge.
- Reset state: state=IDLE, count=0, reg_ab=0, reg_ba=0, a_oe=b_oe=turn=0, a and b high-Z.
- States: IDLE, DRIVE_AB, DRIVE_BA, TURN. Outputs are decoded from state only:
  - b_oe = (state==DRIVE_AB)
  - a_oe = (state==DRIVE_BA)
  - turn = (state==TURN)
- Control sampling: dir and g_n are sampled on the rising clk edge. Every drive change takes effect one clock after the sample; there is no combinational enable path.
- IDLE:
  - g_n=0 and dir=1 -> DRIVE_AB
  - g_n=0 and dir=0 -> DRIVE_BA
  - otherwise stay in IDLE
  - No dead time is needed from IDLE.
- DRIVE_AB:
  - g_n=1 -> IDLE
  - g_n=0 and dir=0 -> TURN, count loaded with TURN_CYCLES
  - otherwise stay
- DRIVE_BA: mirror of DRIVE_AB; dir=1 -> TURN.
- TURN:
  - Neither bus is driven.
  - count decrements each clock while count>1.
  - When count==1, exit on the next edge using dir/g_n sampled at that edge: g_n=1 -> IDLE, dir=1 -> DRIVE_AB, dir=0 -> DRIVE_BA.
  - dir toggling back during TURN does not shorten the dead time; TURN always lasts exactly TURN_CYCLES cycles.
  - g_n=1 during TURN does not abort early; exit is to IDLE.
- Drive values (combinational from current data):
  - b = b_oe ? (sab ? reg_ab : a) : Z
  - a = a_oe ? (sba ? reg_ba : b) : Z
  - Both sides are never driven in the same cycle, by construction.
- Storage registers:
  - lat_ab=1 at an edge captures a into reg_ab; lat_ba=1 captures b into reg_ba.
  - Capture works in any state, including IDLE and TURN.
  - Capturing the side the block is currently driving stores the driven value.
  - lat_ab and lat_ba in the same cycle both capture.
  - sab/sba changes take effect immediately (combinational mux).
- Reset mid-operation: at the next edge, drivers release, state goes to IDLE and registers clear, even mid-TURN.

Test Plan:
- Reset, then g_n=0, dir=1, sab=0, a=8'hA5 -> b_oe=1 one cycle later; b=8'hA5; a_oe=0; before that edge b=Z.
- DRIVE_AB with TURN_CYCLES=2, dir goes 0 -> b=Z, turn=1 for exactly 2 cycles, then a_oe=1; b=8'h3C gives a=8'h3C. No cycle has a_oe&b_oe.
- lat_ab=1 with a=8'h5A for one edge, then a=8'hFF, sab=1, DRIVE_AB -> b=8'h5A. Switching sab=0 the same cycle gives b=8'hFF immediately.
- In TURN, set g_n=1 and toggle dir -> TURN still lasts TURN_CYCLES cycles, then IDLE; a, b both Z; a_oe=b_oe=0.
- DRIVE_BA with reg_ba=8'h77, assert reset for one edge -> a=Z, a_oe=0, reg_ba=0. Then sba=1 and re-enable with dir=0 -> a=8'h00.
- WIDTH=16: IDLE -> DRIVE_AB with a=16'hBEEF -> b=16'hBEEF.
